// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a
// per-register busy (pending-write) scoreboard with a registered busy count.
module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wEn,
   input  logic [ADDR_W-1:0] write_sel,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_sel1,
   input  logic [ADDR_W-1:0] read_sel2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_sel,
   output logic              rsv_stall,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   busy_count
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;
   logic [ADDR_W:0]     r_busy_count;

   logic                w_wr_ok;
   logic                w_rsv_set;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic [ADDR_W-1:0]   w_rsel  [2];
   logic [DATA_W-1:0]   w_rdata [2];
   logic                w_rbusy [2];

   function automatic logic [ADDR_W:0] f_popcount(input logic [NUM_REGS-1:0] v);
      logic [ADDR_W:0] c;
      c = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         c = c + {{ADDR_W{1'b0}}, v[i]};
      end
      return c;
   endfunction

   function automatic logic f_is_zero_reg(input logic [ADDR_W-1:0] sel);
      return (ZERO_REG != 0) && (sel == '0);
   endfunction

   assign w_wr_ok  = wEn && !f_is_zero_reg(write_sel);
   assign w_rsel[0] = read_sel1;
   assign w_rsel[1] = read_sel2;

   // Reservation refusal: a same-cycle write to the target frees it, so no stall then
   always_comb begin
      rsv_stall = 1'b0;
      if (!reset && rsv_en && r_busy[rsv_sel] && !(wEn && (write_sel == rsv_sel))) begin
         rsv_stall = 1'b1;
      end else begin
         rsv_stall = 1'b0;
      end
   end

   assign w_rsv_set = rsv_en && !rsv_stall && !f_is_zero_reg(rsv_sel);

   // Next busy vector: write clears, accepted reservation sets and wins on collision
   always_comb begin
      w_busy_nxt = r_busy;
      if (wEn) begin
         w_busy_nxt[write_sel] = 1'b0;
      end else begin
         w_busy_nxt = r_busy;
      end
      if (w_rsv_set) begin
         w_busy_nxt[rsv_sel] = 1'b1;
      end else begin
         w_busy_nxt[rsv_sel] = w_busy_nxt[rsv_sel];
      end
   end

   // Read ports with optional write forwarding; reset forces quiet outputs
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rdata[p] = r_regs[w_rsel[p]];
         w_rbusy[p] = r_busy[w_rsel[p]];
         if (reset || f_is_zero_reg(w_rsel[p])) begin
            w_rdata[p] = '0;
            w_rbusy[p] = 1'b0;
         end else if ((BYPASS != 0) && w_wr_ok && (write_sel == w_rsel[p])) begin
            w_rdata[p] = write_data;
            w_rbusy[p] = 1'b0;
         end else begin
            w_rdata[p] = r_regs[w_rsel[p]];
            w_rbusy[p] = r_busy[w_rsel[p]];
         end
      end
   end

   assign read_data1 = w_rdata[0];
   assign read_data2 = w_rdata[1];
   assign busy1      = w_rbusy[0];
   assign busy2      = w_rbusy[1];
   assign busy_count = r_busy_count;

   // Register array; index 0 is never written when hardwired to zero
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_regs[write_sel] <= write_data;
      end else begin
         r_regs[write_sel] <= r_regs[write_sel];
      end
   end

   // Busy scoreboard and its population count
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_busy       <= '0;
         r_busy_count <= '0;
      end else begin
         r_busy       <= w_busy_nxt;
         r_busy_count <= f_popcount(w_busy_nxt);
      end
   end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning select width; NUM_REGS = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled when 1.
REQ-005 The block SHALL have port clock, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning the reset; it is asynchronous and active-high.
REQ-007 The block SHALL have port wEn, input, 1, meaning write enable.
REQ-008 The block SHALL have port write_sel, input, ADDR_W, meaning the write register index.
REQ-009 The block SHALL have port write_data, input, DATA_W, meaning the write value.
REQ-010 The block SHALL have ports read_sel1 and read_sel2, input, ADDR_W, meaning the read register indices.
REQ-011 The block SHALL have ports read_data1 and read_data2, output, DATA_W, meaning the combinational read values.
REQ-012 The block SHALL have port rsv_en, input, 1, meaning a request to reserve a register as pending-write.
REQ-013 The block SHALL have port rsv_sel, input, ADDR_W, meaning the index to reserve.
REQ-014 The block SHALL have port rsv_stall, output, 1, meaning the reservation is refused this cycle.
REQ-015 The block SHALL have ports busy1 and busy2, output, 1, meaning the operand behind read_sel1/read_sel2 is pending.
REQ-016 The block SHALL have port busy_count, output, ADDR_W+1, meaning the registered count of set busy bits.

Function
REQ-017 The block SHALL write write_data to reg[write_sel] on the rising edge when wEn=1, except to index 0 when ZERO_REG=1.
REQ-018 The block SHALL drive read_dataN from reg[read_selN] combinationally, with zero-latency reads.
REQ-019 With ZERO_REG=1, the block SHALL drive read_dataN=0 and busyN=0 whenever read_selN=0, regardless of writes or reservations.
REQ-020 With BYPASS=1, when wEn=1, write_sel=read_selN and the write is not suppressed by REQ-017, the block SHALL drive read_dataN=write_data in the same cycle.
REQ-021 With BYPASS=0, the block SHALL drive read_dataN with the pre-edge register contents during a colliding write.
REQ-022 The block SHALL keep one busy bit per register, clear at reset.
REQ-023 On an edge with wEn=1, the block SHALL clear busy[write_sel]; the write itself is never blocked by busy.
REQ-024 The block SHALL drive rsv_stall=1 combinationally iff rsv_en=1, busy[rsv_sel]=1, and no same-cycle write to rsv_sel is occurring (wEn=0 or write_sel!=rsv_sel).
REQ-025 On an edge with rsv_en=1 and rsv_stall=0, the block SHALL set busy[rsv_sel]; with rsv_sel=0 and ZERO_REG=1 the reservation SHALL be accepted but no bit SHALL be set.
REQ-026 When a write and an accepted reservation target the same index on the same edge, the block SHALL apply set priority: data is written and busy remains 1, because the reservation represents a new producer.
REQ-027 The block SHALL drive busyN = busy[read_selN], except that with BYPASS=1 and a same-cycle write to read_selN it SHALL drive busyN=0.
REQ-028 The block SHALL update busy_count on each edge to the population count of the next-state busy vector; its maximum is NUM_REGS-1 when ZERO_REG=1, otherwise NUM_REGS.
REQ-029 The block SHALL ignore X-free out-of-range conditions, since all selects are fully decoded and no index is invalid.

Reset
REQ-030 On assertion of reset, the block SHALL asynchronously clear all registers to 0, all busy bits, and busy_count, without waiting for a clock edge.
REQ-031 While reset=1, the block SHALL ignore wEn and rsv_en; read_dataN SHALL read 0; busyN and rsv_stall SHALL be 0.
REQ-032 When reset is asserted mid-operation, the block SHALL discard pending reservations and in-flight writes on that edge.

Verification
REQ-033 The bench SHALL check zero register: reset, then wEn=1, write_sel=0, write_data=FFFFFFFF, one edge -> read_sel1=0 reads 00000000; then write_sel=1 with the same data -> reg1=FFFFFFFF.
REQ-034 The bench SHALL check bypass: wEn=1, write_sel=5, write_data=A5A5A5A5, read_sel2=5, before the edge -> read_data2=A5A5A5A5 (BYPASS=1); rebuilt with BYPASS=0 -> old value 00000000.
REQ-035 The bench SHALL check the reserve/stall cycle: rsv_en=1, rsv_sel=7, one edge -> busy_count=1 and busy1=1 at read_sel1=7; rsv_sel=7 again -> rsv_stall=1 and count stays 1; wEn to 7 -> busy clears and count=0.
REQ-036 The bench SHALL check same-edge write plus reserve: with reg 3 busy, wEn=1, write_sel=3, data=12345678, rsv_en=1, rsv_sel=3 -> rsv_stall=0; after the edge reg3=12345678, busy[3]=1, count unchanged.
REQ-037 The bench SHALL check parametrisation: rebuild with DATA_W=16, ADDR_W=3, ZERO_REG=0, reserve all 8 registers -> busy_count=8; write_sel=0 data=BEEF -> reads BEEF.
REQ-038 The bench SHALL check asynchronous reset: with 4 busy bits set and reg2=0000FFFF, assert reset between edges -> busy_count=0, read_data of reg 2=0, all busyN=0 immediately.
